weave_row_sequencer: RTL
========================

# weave_row_sequencer

Downstream stage of the tile's operand adder. Accepts the 8-bit summed word as a warp-lift mask over a valid/ready handshake and buffers it in a small FIFO. Presents each mask to the output pins as one weave row for a fixed number of cycles. Optionally applies a twill rotation per row so that successive rows form a diagonal weave.

## Interface
Parameters:
- DEPTH, 4: FIFO entries. Power of two, ≥2.
- HOLD_CYCLES, 4: cycles each row is presented. ≥1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- in_data  in  8  lift mask from the adder stage.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  a word is accepted on a clock edge when in_valid && in_ready.
- out_row  out  8  current weave row (registered).
- out_valid  out  1  out_row holds a live row.
- row_idx  out  3  index of the current row, mod 8.
- row_start  out  1  one-cycle pulse in the first cycle of each row.

## Operation
- Reset values: in_ready=1, out_row=0, out_valid=0, row_idx=0, row_start=0, FIFO empty, FSM=IDLE, hold counter=0.
- FIFO:
  - in_ready = !full, computed from the registered count only.
  - When full, a word is not accepted even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, SHOW.
  - IDLE and FIFO non-empty: pop, load out_row, out_valid←1, row_start←1, hold←HOLD_CYCLES-1, go to SHOW.
  - SHOW with hold>0: hold decrements. row_start←0.
  - SHOW with hold==0 and FIFO non-empty: pop the next word back-to-back. out_valid stays 1, row_start←1, hold reloads, row_idx increments.
  - SHOW with hold==0 and FIFO empty: out_valid←0, go to IDLE. out_row keeps its last value.
- row_idx:
  - Increments on every row load except the first load after reset. The first row after reset is index 0.
  - Wraps 7→0.
  - Does not reset on return to IDLE.
- Row value:
  - With the feature compiled in: out_row = word rotated left by the row_idx assigned to that row.
  - With the feature compiled out: out_row = word.
- An asynchronous reset at any point, including mid-SHOW, returns every register to its reset value immediately. Buffered words are discarded.

## Timing
- Latency: a word accepted at edge E into an empty FIFO, with FSM in IDLE, appears on out_row with out_valid=1 after edge E+1.
- Each row stays on out_row for exactly HOLD_CYCLES cycles.
- Consecutive buffered rows have no gap: out_valid stays continuously high.
- row_start is high in exactly one cycle per row, aligned with the first cycle that row is presented.
- Sustained throughput: one word per HOLD_CYCLES cycles. Upstream sees in_ready=0 once DEPTH words are pending.

## Configuration
- WEAVE_TWILL_SHIFT_EN defined: per-row left rotation by row_idx is compiled in.
- WEAVE_TWILL_SHIFT_EN undefined:
  - Rotation logic is absent and out_row is the raw popped word.
  - row_idx still counts.

## Structure
- Package weave_pkg:
  - ROW_W=8 and ROW_IDX_W=3.
  - State enum type (IDLE, SHOW).
  - rotl8 function (word, amount).
- Sub-module weave_fifo:
  - Synchronous FIFO, parameters DEPTH and width.
  - Outputs full, empty, and count.
  - Asynchronous active-low reset.
- All other logic (FSM, hold counter, row index, rotation) sits in weave_row_sequencer.

## Test plan
- Reset: hold rst_n low, then release. Check in_ready=1, out_valid=0, out_row=0x00, row_idx=0, row_start=0.
- Single word: push 0x3C at edge E. Check out_row=0x3C and out_valid=1 after E+1, held 4 cycles, then out_valid=0.
- Twill diagonal (macro on): push 0x01 ×3 back-to-back. Check rows 0x01, 0x02, 0x04 with continuous out_valid, row_start pulses 4 cycles apart, and row_idx 0, 1, 2.
- Backpressure: hold in_valid high with words 0x10..0x15. Check in_ready drops once 4 words are pending and no word is lost or duplicated. Output order must match input order.
- Wrap and passthrough: push 9 words of 0x81. Macro on: row 8 is 0x81 with row_idx=0 again after 7. Macro off: all rows are 0x81.
- Mid-row reset: assert rst_n low during the second cycle of a row with 2 words pending. Check all outputs return to reset values immediately, and no stale row appears after release.

Source files
------------

// File: rtl/weave_pkg.sv
// weave_pkg: shared types and helpers for the weave row sequencer.
//   ROW_W      - width of one weave row / lift mask (8)
//   ROW_IDX_W  - width of the row index (3, counts rows mod 8)
//   state_t    - sequencer FSM states (IDLE, SHOW)
//   rotl8      - rotate an 8-bit row left by 0..7 positions
package weave_pkg;

  localparam int ROW_W     = 8;
  localparam int ROW_IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Rotating the doubled word left and keeping the upper half gives a
  // circular left rotation without a variable-width right shift.
  function automatic logic [ROW_W-1:0] rotl8(input logic [ROW_W-1:0]     word,
                                             input logic [ROW_IDX_W-1:0] amount);
    logic [2*ROW_W-1:0] dbl;
    dbl = {word, word} << amount;
    return dbl[2*ROW_W-1:ROW_W];
  endfunction

endpackage

// File: rtl/weave_fifo.sv
// weave_fifo: synchronous FIFO buffering lift masks ahead of the sequencer.
// Parameters: DEPTH (power of two, >= 2), WIDTH, CNT_W (count width).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, din       write request and data (ignored when full)
//   pop, dout       read request and head-of-queue data (ignored when empty)
//   full, empty     status derived from the registered count
//   count           number of stored words
// A push while full is dropped even if a pop happens in the same cycle.
module weave_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset: contents are only visible once counted in.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/weave_row_sequencer.sv
// weave_row_sequencer: buffers lift masks from the operand adder and presents
// each one as a weave row on out_row for HOLD_CYCLES cycles.
// Build option: define WEAVE_TWILL_SHIFT_EN to rotate each row left by its
// row index (twill diagonal); otherwise rows are the raw words.
// Parameters: DEPTH (FIFO entries, power of two >= 2), HOLD_CYCLES (>= 1).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      lift mask from the adder stage
//   in_valid     in_data is valid
//   in_ready     word accepted on an edge where in_valid && in_ready
//   out_row      current weave row (registered)
//   out_valid    out_row holds a live row
//   row_idx      index of the current row, mod 8
//   row_start    one-cycle pulse in the first cycle of each row
// Handshake: in_valid/in_ready follow strict valid/ready rules -- a transfer
// happens on exactly the edges where both are high; in_ready depends only on
// registered FIFO occupancy, never on in_valid.
module weave_row_sequencer
  import weave_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ROW_W-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ROW_W-1:0]     out_row,
  output logic                 out_valid,
  output logic [ROW_IDX_W-1:0] row_idx,
  output logic                 row_start
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t               state, state_n;
  logic [HOLD_W-1:0]    hold, hold_n;
  logic [ROW_W-1:0]     out_row_n;
  logic                 out_valid_n;
  logic                 row_start_n;
  logic [ROW_IDX_W-1:0] row_idx_n;
  logic                 loaded, loaded_n;   // a row has been loaded since reset
  logic                 load;
  logic [ROW_IDX_W-1:0] load_idx;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [ROW_W-1:0]     fifo_dout;

  assign in_ready = !fifo_full;

  weave_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ROW_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (in_data),
    .pop   (load),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Status flags must always agree with the occupancy count.
  a_fifo_flags: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_full == (fifo_count == CNT_W'(DEPTH))) && (fifo_empty == (fifo_count == '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      out_row   <= '0;
      out_valid <= 1'b0;
      row_start <= 1'b0;
      row_idx   <= '0;
      loaded    <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      out_row   <= out_row_n;
      out_valid <= out_valid_n;
      row_start <= row_start_n;
      row_idx   <= row_idx_n;
      loaded    <= loaded_n;
    end
  end

  always_comb begin
    state_n     = state;
    hold_n      = hold;
    out_row_n   = out_row;
    out_valid_n = out_valid;
    row_start_n = 1'b0;
    row_idx_n   = row_idx;
    loaded_n    = loaded;
    load        = 1'b0;
    load_idx    = row_idx;

    case (state)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      SHOW: begin
        if (hold != '0) begin
          hold_n = hold - 1'b1;
        end else if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          out_valid_n = 1'b0;   // out_row keeps its last value
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      // The very first row after reset keeps index 0; later rows advance it.
      load_idx    = loaded ? row_idx + 1'b1 : row_idx;
      row_idx_n   = load_idx;
`ifdef WEAVE_TWILL_SHIFT_EN
      out_row_n   = rotl8(fifo_dout, load_idx);
`else
      out_row_n   = fifo_dout;
`endif
      out_valid_n = 1'b1;
      row_start_n = 1'b1;
      hold_n      = HOLD_RELOAD;
      state_n     = SHOW;
      loaded_n    = 1'b1;
    end
  end

endmodule
